// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, field positions.
// Used by cp0_exc_ctrl and, when CP0_TIMER_EN is defined, by cp0_timer.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int IM_LO     = 10;
    localparam int IM_HI     = 15;
    localparam int CAUSE_BD  = 31;
    localparam int EXC_LO    = 2;
    localparam int EXC_HI    = 6;
    localparam int TIMER_IRQ = 5;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a pending flag; only built when CP0_TIMER_EN is defined.
// Count free-runs and wraps; writing Compare clears the pending flag.
`ifdef CP0_TIMER_EN
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pend
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            compare <= '0;
            pend    <= 1'b0;
        end else begin
            count <= (wr_en && addr == REG_COUNT) ? din : count + 32'd1;
            if (wr_en && addr == REG_COMPARE) begin
                compare <= din;
                pend    <= 1'b0;
            end else if (count == compare && compare != '0) begin
                pend <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cp0_exc_ctrl.sv
// M-stage CP0 exception/interrupt controller: SR/Cause/EPC/PRId, trap and eret redirect.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_NORMAL  | SR.EXL=0, traps accepted
// ST_HANDLER | SR.EXL=1, in handler; traps masked, eret returns to EPC
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h1234_5678,
    parameter int          NUM_HWINT    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_m,
    input  logic [4:0]           exc_m,
    input  logic                 bd_m,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          din,
    input  logic                 eret_m,
    output logic [31:0]          dout,
    output logic                 cp0_jump,
    output logic [31:0]          cp0_npc,
    output logic [31:0]          epc_out
);

    cp0_state_e  state;
    logic [5:0]  im;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  code;
    logic [31:0] epc;

    logic        exl;
    logic [5:0]  hw_ext;
    logic [5:0]  hw_eff;
    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        wr_en;
    logic [31:0] epc_target;

    generate
        if (NUM_HWINT >= 6) begin : g_hw_full
            assign hw_ext = hwint[5:0];
        end else begin : g_hw_pad
            assign hw_ext = {{(6-NUM_HWINT){1'b0}}, hwint};
        end
    endgenerate

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;

    cp0_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .addr    (addr),
        .din     (din),
        .count   (count),
        .compare (compare),
        .pend    (timer_pend)
    );

    // Timer pending behaves like external line IP15, before masking.
    assign hw_eff = hw_ext | ({5'b0, timer_pend} << TIMER_IRQ);
`else
    assign hw_eff = hw_ext;
`endif

    assign exl        = (state == ST_HANDLER);
    assign int_req    = (|(hw_eff & im)) & ie & ~exl;
    assign exc_req    = (exc_m != EXC_INT) & ~exl;
    assign take       = int_req | exc_req;
    // The trapping instruction must not commit its mtc0.
    assign wr_en      = we & ~take;
    assign epc_target = (bd_m ? pc_m - 32'd4 : pc_m) & WORD_MASK;

    assign cp0_jump = take | (eret_m & exl);
    assign cp0_npc  = take ? HANDLER_ADDR : epc;
    assign epc_out  = epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_NORMAL;
            im    <= '0;
            ie    <= 1'b0;
            bd    <= 1'b0;
            ip    <= '0;
            code  <= EXC_INT;
            epc   <= '0;
        end else begin
            ip <= hw_eff;
            if (take) begin
                state <= ST_HANDLER;
                code  <= int_req ? EXC_INT : exc_m;
                bd    <= bd_m;
                epc   <= epc_target;
            end else begin
                if (wr_en && addr == REG_SR) begin
                    im    <= din[IM_HI:IM_LO];
                    ie    <= din[SR_IE];
                    state <= din[SR_EXL] ? ST_HANDLER : ST_NORMAL;
                end
                if (wr_en && addr == REG_EPC) begin
                    epc <= din & WORD_MASK;
                end
                // eret overrides a simultaneous SR write on EXL.
                if (eret_m && exl) begin
                    state <= ST_NORMAL;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            REG_SR:      dout = {16'b0, im, 8'b0, exl, ie};
            REG_CAUSE:   dout = {bd, 15'b0, ip, 3'b0, code, 2'b0};
            REG_EPC:     dout = epc;
            REG_PRID:    dout = PRID_VAL;
`ifdef CP0_TIMER_EN
            REG_COUNT:   dout = count;
            REG_COMPARE: dout = compare;
`endif
            default:     dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a register-level behavioural model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] HADDR = 32'h0000_4180;
    localparam logic [31:0] PRID  = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m;
    logic [4:0]  exc_m;
    logic        bd_m;
    logic [5:0]  hwint;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        eret_m;
    logic [31:0] dout;
    logic        cp0_jump;
    logic [31:0] cp0_npc;
    logic [31:0] epc_out;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_exc_ctrl #(
        .HANDLER_ADDR (HADDR),
        .PRID_VAL     (PRID),
        .NUM_HWINT    (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_m     (pc_m),
        .exc_m    (exc_m),
        .bd_m     (bd_m),
        .hwint    (hwint),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .eret_m   (eret_m),
        .dout     (dout),
        .cp0_jump (cp0_jump),
        .cp0_npc  (cp0_npc),
        .epc_out  (epc_out)
    );

    always #5 clk = ~clk;

    // Architectural model: plain field variables
    int unsigned m_im, m_exl, m_ie, m_bd, m_ip, m_code, m_epc;
    int unsigned m_count, m_compare, m_pend;

    task automatic model_reset();
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = 0; m_code = 0; m_epc = 0;
        m_count = 0; m_compare = 0; m_pend = 0;
    endtask

    function automatic int unsigned eff_hw();
        int unsigned h;
        h = int'(hwint);
`ifdef CP0_TIMER_EN
        if (m_pend != 0) h = h | 32;
`endif
        return h;
    endfunction

    function automatic bit m_int_req();
        return ((eff_hw() & m_im) != 0) && (m_ie != 0) && (m_exl == 0);
    endfunction

    function automatic bit m_take();
        return m_int_req() || ((exc_m != 0) && (m_exl == 0));
    endfunction

    function automatic int unsigned m_dout(input int unsigned a);
        case (a)
            12: return (m_im << 10) + (m_exl << 1) + m_ie;
            13: return (m_bd << 31) + (m_ip << 10) + (m_code << 2);
            14: return m_epc;
            15: return PRID;
`ifdef CP0_TIMER_EN
            9:  return m_count;
            11: return m_compare;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit          t, ir, old_exl, wr;
        int unsigned old_cnt, old_cmp;
        t       = m_take();
        ir      = m_int_req();
        old_exl = (m_exl != 0);
        wr      = we && !t;
        old_cnt = m_count;
        old_cmp = m_compare;
        m_ip    = eff_hw();
        if (t) begin
            m_exl  = 1;
            m_code = ir ? 0 : int'(exc_m);
            m_bd   = bd_m;
            m_epc  = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
        end else begin
            if (wr && addr == 12) begin
                m_im  = (din >> 10) & 6'h3F;
                m_exl = din[1];
                m_ie  = din[0];
            end
            if (wr && addr == 14) m_epc = din & 32'hFFFF_FFFC;
            if (eret_m && old_exl) m_exl = 0;
        end
`ifdef CP0_TIMER_EN
        m_count = (wr && addr == 9) ? din : old_cnt + 1;
        if (wr && addr == 11) begin
            m_compare = din;
            m_pend    = 0;
        end else if (old_cnt == old_cmp && old_cmp != 0) begin
            m_pend = 1;
        end
`else
        if (old_cnt != old_cmp) m_count = old_cnt;
`endif
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model; called once per cycle after inputs settle.
    task automatic cmp_cycle();
        #1;
        chk("jump",    {31'b0, cp0_jump}, {31'b0, m_take() || (eret_m && m_exl != 0)});
        chk("npc",     cp0_npc, m_take() ? HADDR : m_epc);
        chk("epc_out", epc_out, m_epc);
        chk("dout",    dout,    m_dout(int'(addr)));
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] exc, input logic bd,
                         input logic [5:0] hw, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic er);
        pc_m = pc; exc_m = exc; bd_m = bd; hwint = hw;
        we = w; addr = a; din = d; eret_m = er;
    endtask

    task automatic idle_read(input logic [4:0] a);
        drive(32'h0, 5'd0, 1'b0, 6'd0, 1'b0, a, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        idle_read(5'd12);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Post-reset register contents
        idle_read(5'd12); cmp_cycle(); chk("rst_sr", dout, 32'h0);
        chk("rst_jump", {31'b0, cp0_jump}, 32'h0); finish_cycle();
        idle_read(5'd13); cmp_cycle(); chk("rst_cause", dout, 32'h0); finish_cycle();
        idle_read(5'd14); cmp_cycle(); chk("rst_epc", dout, 32'h0); finish_cycle();
        idle_read(5'd15); cmp_cycle(); chk("rst_prid", dout, PRID); finish_cycle();

        // Interrupt trap
        drive(32'h0, 5'd0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_FC01, 1'b0);
        cmp_cycle(); finish_cycle();
        drive(32'h3010, 5'd0, 1'b0, 6'b000100, 1'b0, 5'd12, 32'h0, 1'b0);
        cmp_cycle();
        chk("int_jump", {31'b0, cp0_jump}, 32'h1);
        chk("int_npc", cp0_npc, 32'h0000_4180);
        finish_cycle();
        idle_read(5'd14); cmp_cycle(); chk("int_epc", dout, 32'h0000_3010); finish_cycle();
        idle_read(5'd13); cmp_cycle(); chk("int_cause", dout, 32'h0); finish_cycle();
        idle_read(5'd12); cmp_cycle(); chk("int_sr", dout, 32'h0000_FC03); finish_cycle();

        // In handler: exception and interrupt masked, then eret
        drive(32'h5000, 5'd4, 1'b0, 6'b000100, 1'b0, 5'd12, 32'h0, 1'b0);
        cmp_cycle(); chk("exl_mask_jump", {31'b0, cp0_jump}, 32'h0); finish_cycle();
        drive(32'h5004, 5'd0, 1'b0, 6'd0, 1'b0, 5'd12, 32'h0, 1'b1);
        cmp_cycle();
        chk("eret_jump", {31'b0, cp0_jump}, 32'h1);
        chk("eret_npc", cp0_npc, 32'h0000_3010);
        finish_cycle();
        drive(32'h0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd12, 32'h0, 1'b1);
        cmp_cycle();
        chk("eret_noexl_jump", {31'b0, cp0_jump}, 32'h0);
        chk("eret_sr", dout, 32'h0000_FC01);
        finish_cycle();

        // Exception in delay slot with IE=0; concurrent mtc0 must not commit
        drive(32'h0, 5'd0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_FC00, 1'b0);
        cmp_cycle(); finish_cycle();
        drive(32'h3024, 5'd12, 1'b1, 6'd0, 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0);
        cmp_cycle();
        chk("ov_jump", {31'b0, cp0_jump}, 32'h1);
        chk("ov_npc", cp0_npc, 32'h0000_4180);
        finish_cycle();
        idle_read(5'd14); cmp_cycle(); chk("ov_epc", dout, 32'h0000_3020); finish_cycle();
        idle_read(5'd13); cmp_cycle(); chk("ov_cause", dout, 32'h8000_0030); finish_cycle();

        // Asynchronous reset in the middle of the handler
        idle_read(5'd14);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("arst_epc", dout, 32'h0);
        chk("arst_epc_out", epc_out, 32'h0);
        chk("arst_jump", {31'b0, cp0_jump}, 32'h0);
        addr = 5'd12; #1; chk("arst_sr", dout, 32'h0);
        addr = 5'd13; #1; chk("arst_cause", dout, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            logic [4:0]  ex;
            logic [5:0]  hw;
            logic [4:0]  a;
            pc = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            case ($urandom_range(0, 11))
                0: ex = 5'd4;
                1: ex = 5'd5;
                2: ex = 5'd10;
                3: ex = 5'd12;
                4: ex = 5'($urandom_range(1, 31));
                default: ex = 5'd0;
            endcase
            hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            case ($urandom_range(0, 7))
                0: a = 5'd9;
                1: a = 5'd11;
                2, 3: a = 5'd12;
                4: a = 5'd13;
                5: a = 5'd14;
                6: a = 5'd15;
                default: a = 5'($urandom);
            endcase
            drive(pc, ex, 1'($urandom), hw, ($urandom_range(0, 2) == 0), a, $urandom,
                  ($urandom_range(0, 3) == 0));
            cmp_cycle();
            finish_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
